fft_run_ctrl: RTL and testbench

Synthesizable run controller for the FFT datapath. It sequences RAM load, compute and completion for the `read_input` loader and the `fft` core, replacing the hand-written stimulus FSM in benches. Over that FSM it adds single-shot and continuous (back-to-back frame) modes, per-phase timeouts, loader-error capture, abort, and a frame counter. It sits above `read_input`/`fft` and drives their `ld_data`/`en` controls.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/phase_timer.sv | 24 ++
 rtl/fft_run_ctrl.sv | 110 +++++++++++
 tb/tb_fft_run_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared encodings for the FFT run controller: FSM states and error codes.
package fft_pkg;

  // ERROR extends the original IDLE..DONE values.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LDRAM   = 3'b001,
    S_RAMRDY  = 3'b010,
    S_RUNNING = 3'b011,
    S_DONE    = 3'b100,
    S_ERROR   = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LD_TMO  = 2'b01,
    ERR_RUN_TMO = 2'b10,
    ERR_INIT    = 2'b11
  } err_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counter with clear and enable; flags the cycle where the count reaches limit-1.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         terminal
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  // Terminal only matters while counting, so idle phases never raise it.
  assign terminal = en && (cnt == limit - W'(1));

endmodule

// File: rtl/fft_run_ctrl.sv
// Run controller sequencing load, settle, compute and completion for the FFT datapath.
module fft_run_ctrl
  import fft_pkg::*;
#(
  parameter int LD_TIMEOUT  = 64,
  parameter int RUN_TIMEOUT = 256,
  parameter int FRAMECNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic                  ld_done,
  input  logic                  init_error,
  input  logic                  fft_done,
  output logic                  ld_data,
  output logic                  en,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FRAMECNT_W-1:0] frame_count,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int CW = $clog2(max2(LD_TIMEOUT, RUN_TIMEOUT) + 1);

  state_t        state, nxt;
  err_t          code_q, nxt_code;
  logic          hold;
  logic          tmo, tmr_clr, tmr_en;
  logic [CW-1:0] limit;

  assign limit   = (state == S_RUNNING) ? CW'(RUN_TIMEOUT) : CW'(LD_TIMEOUT);
  assign tmr_en  = (state == S_LDRAM) || (state == S_RUNNING);
  assign tmr_clr = (nxt != state);

  phase_timer #(.W(CW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .limit    (limit),
    .terminal (tmo)
  );

  always_comb begin
    nxt      = state;
    nxt_code = code_q;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nxt      = S_LDRAM;
          nxt_code = ERR_NONE;
        end
        S_LDRAM: begin
          if (init_error) begin
            nxt      = S_ERROR;
            nxt_code = ERR_INIT;
          end else if (ld_done) begin
            nxt = S_RAMRDY;
          end else if (tmo) begin
            nxt      = S_ERROR;
            nxt_code = ERR_LD_TMO;
          end
        end
        S_RAMRDY: nxt = S_RUNNING;
        S_RUNNING: begin
          if (fft_done) begin
            nxt = S_DONE;
          end else if (tmo) begin
            nxt      = S_ERROR;
            nxt_code = ERR_RUN_TMO;
          end
        end
        S_DONE: begin
          if (continuous)  nxt = S_LDRAM;
          else if (!start) nxt = S_IDLE;
        end
        S_ERROR: if (!start) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      code_q      <= ERR_NONE;
      hold        <= 1'b0;
      frame_count <= '0;
    end else begin
      state  <= nxt;
      code_q <= nxt_code;
      // Staying in DONE means waiting for start to drop; mute the pulse.
      hold   <= (state == S_DONE) && (nxt == S_DONE);
      if (frame_done) frame_count <= frame_count + FRAMECNT_W'(1);
    end
  end

  assign ld_data    = (state == S_LDRAM);
  assign en         = (state == S_RUNNING);
  assign busy       = (state != S_IDLE) && (state != S_ERROR);
  assign frame_done = (state == S_DONE) && !hold;
  assign error      = (code_q != ERR_NONE);
  assign err_code   = code_q;

endmodule

// File: tb/tb_fft_run_ctrl.sv
// Self-checking bench for fft_run_ctrl: cycle checks plus a frame_done scoreboard.
module tb_fft_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, abort, ld_done, init_error, fft_done;
  logic       ld_data, en, busy, frame_done, error;
  logic [7:0] frame_count;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int fc_exp  = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  fft_run_ctrl #(.LD_TIMEOUT(8), .RUN_TIMEOUT(32), .FRAMECNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .ld_done(ld_done), .init_error(init_error), .fft_done(fft_done),
    .ld_data(ld_data), .en(en), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .error(error), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: frame_count seen during each pulse must equal the pre-increment value.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (sb_q.size() == 0) chk("unexpected_frame_done", 1, 0);
      else                  chk("fd_count", frame_count, sb_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    {start, continuous, abort, ld_done, init_error, fft_done} = '0;
    sb_q.delete();
    fc_exp = 0;
    tick();
    rst_n = 1'b1;
  endtask

  // Called on the first LDRAM cycle; leaves the bench on the first RUNNING cycle.
  task automatic load_phase(input int n);
    for (int i = 1; i <= n; i++) begin
      chk("ld_data_hi", ld_data, 1);
      if (i == n) ld_done = 1'b1;
      tick();
    end
    ld_done = 1'b0;
    chk("settle_ld", ld_data, 0);
    chk("settle_en", en, 0);
    tick();
  endtask

  // Leaves the bench on the first DONE cycle.
  task automatic run_phase(input int n);
    for (int i = 1; i <= n; i++) begin
      chk("en_hi", en, 1);
      if (i == n) begin
        fft_done = 1'b1;
        sb_q.push_back(fc_exp);
        fc_exp++;
      end
      tick();
    end
    fft_done = 1'b0;
    chk("done_pulse", frame_done, 1);
    chk("done_en", en, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {start, continuous, abort, ld_done, init_error, fft_done} = '0;
    #12;
    chk("rst_ld_data", ld_data, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frame_count", frame_count, 0);
    do_reset();

    // Stray completions in IDLE are ignored.
    ld_done = 1'b1; fft_done = 1'b1;
    tick();
    chk("idle_ignore", busy, 0);
    ld_done = 1'b0; fft_done = 1'b0;

    // Single shot.
    start = 1'b1;
    tick();
    chk("start_lat", ld_data, 1);
    load_phase(5);
    run_phase(20);
    tick();
    chk("hold_no_pulse", frame_done, 0);
    chk("hold_busy", busy, 1);
    chk("ss_count", frame_count, fc_exp);
    start = 1'b0;
    tick();
    chk("ss_idle", busy, 0);

    // Continuous, three frames; continuous drops before the third DONE.
    do_reset();
    start = 1'b1; continuous = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      load_phase(3 + f);
      if (f == 2) continuous = 1'b0;
      run_phase(4 + f);
      tick();
      if (f < 2) chk("cont_reload", ld_data, 1);
      else       chk("cont_hold", ld_data, 0);
    end
    start = 1'b0;
    tick();
    chk("cont_idle", busy, 0);
    chk("cont_count", frame_count, 3);

    // Load timeout after exactly 8 LDRAM cycles.
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_ld_hi", ld_data, 1);
      tick();
    end
    chk("tmo_error", error, 1);
    chk("tmo_code", err_code, 2'b01);
    chk("tmo_ld_lo", ld_data, 0);
    chk("tmo_busy", busy, 0);
    start = 1'b0;
    tick();
    chk("tmo_sticky", error, 1);
    start = 1'b1;
    tick();
    chk("restart_clr_err", error, 0);
    chk("restart_clr_code", err_code, 0);

    // init_error beats ld_done in the same cycle.
    init_error = 1'b1; ld_done = 1'b1;
    tick();
    init_error = 1'b0; ld_done = 1'b0;
    chk("init_code", err_code, 2'b11);
    chk("init_error", error, 1);
    tick();
    chk("init_no_run", en, 0);
    start = 1'b0;
    tick();

    // Run timeout after 32 RUNNING cycles.
    start = 1'b1;
    tick();
    load_phase(2);
    for (int i = 1; i <= 32; i++) begin
      chk("rtmo_en", en, 1);
      tick();
    end
    chk("rtmo_code", err_code, 2'b10);
    chk("rtmo_en_lo", en, 0);
    start = 1'b0;
    tick();

    // Abort at cycle 10 of a 20-cycle run.
    start = 1'b1;
    tick();
    load_phase(2);
    for (int i = 1; i <= 10; i++) begin
      chk("abort_en", en, 1);
      if (i == 10) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
    chk("abort_en_lo", en, 0);
    chk("abort_idle", busy, 0);
    chk("abort_no_fd", frame_done, 0);
    chk("abort_count", frame_count, fc_exp);
    chk("abort_keeps_err", err_code, 2'b00);
    tick();

    // Asynchronous reset during RUNNING, then a normal frame.
    start = 1'b1;
    tick();
    load_phase(2);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", frame_count, 0);
    sb_q.delete();
    fc_exp = 0;
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    chk("arst_restart", ld_data, 1);
    load_phase(4);
    run_phase(6);
    start = 1'b0;
    tick();
    chk("arst_count_after", frame_count, 1);
    chk("arst_idle", busy, 0);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
